// File: rtl/ext16t32.sv
// Immediate extender: widens IN_W-bit X to OUT_W bits (zero- or sign-extend per Se),
// registered with a one-cycle valid strobe for pipeline alignment.
module ext16t32 #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  X,
    input  logic             Se,
    input  logic             in_valid,
    output logic [OUT_W-1:0] Y,
    output logic             out_valid
);

    logic             fill_bit;
    logic [OUT_W-1:0] ext;

    // Upper bits replicate the sign only when Se is set; low IN_W bits pass through untouched.
    always_comb begin
        fill_bit = Se & X[IN_W-1];
        ext      = {{(OUT_W-IN_W){fill_bit}}, X};
    end

    // Y keeps its last captured value on idle cycles; out_valid is a single-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) Y <= ext;
        end
    end

endmodule

// File: tb/tb_ext16t32.sv
// Directed bench for ext16t32: hand-computed vectors per scenario plus a random sweep
// against a 1-cycle-delayed reference model.
module tb_ext16t32;

    logic        clk;
    logic        rst_n;
    logic [15:0] X;
    logic        Se;
    logic        in_valid;
    logic [31:0] Y;
    logic        out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    ext16t32 #(.IN_W(16), .OUT_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .X        (X),
        .Se       (Se),
        .in_valid (in_valid),
        .Y        (Y),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [15:0] x, input logic se, input logic v);
        @(negedge clk);
        X = x; Se = se; in_valid = v;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; X = 16'h1234; Se = 1'b1; in_valid = 1'b1;
        repeat (2) edge_sample();
        n_cmp++;
        if (Y !== 32'h0) begin n_bad++; $display("FAIL reset_y: got %h want %h", Y, 32'h0); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %b want 0", out_valid); end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        edge_sample();
        n_cmp++;
        if (Y !== 32'h0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle: got %h/%b want 0/0", Y, out_valid);
        end
    endtask

    task automatic test_zero_ext();
        drive(16'h8003, 1'b0, 1'b1);
        edge_sample();
        n_cmp++;
        if (Y !== 32'h00008003) begin n_bad++; $display("FAIL zext_y: got %h want %h", Y, 32'h00008003); end
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL zext_vld: got %b want 1", out_valid); end
    endtask

    task automatic test_sign_ext();
        drive(16'h8003, 1'b1, 1'b1);
        edge_sample();
        n_cmp++;
        if (Y !== 32'hFFFF8003) begin n_bad++; $display("FAIL sext_y: got %h want %h", Y, 32'hFFFF8003); end
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL sext_vld: got %b want 1", out_valid); end
    endtask

    task automatic test_back_to_back();
        drive(16'h7FFF, 1'b0, 1'b1);
        edge_sample();
        n_cmp++;
        if (Y !== 32'h00007FFF || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL b2b_first: got %h/%b want %h/1", Y, out_valid, 32'h00007FFF);
        end
        // Second transfer issued on the very next edge with the opposite mode.
        X = 16'h7FFF; Se = 1'b1; in_valid = 1'b1;
        edge_sample();
        n_cmp++;
        if (Y !== 32'h00007FFF || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL b2b_second: got %h/%b want %h/1", Y, out_valid, 32'h00007FFF);
        end
        X = 16'h8001; Se = 1'b1; in_valid = 1'b1;
        edge_sample();
        n_cmp++;
        if (Y !== 32'hFFFF8001 || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL b2b_third: got %h/%b want %h/1", Y, out_valid, 32'hFFFF8001);
        end
        // Idle with a different X present: Y must hold the last capture.
        X = 16'h0055; Se = 1'b0; in_valid = 1'b0;
        edge_sample();
        n_cmp++;
        if (Y !== 32'hFFFF8001 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL b2b_hold: got %h/%b want %h/0", Y, out_valid, 32'hFFFF8001);
        end
    endtask

    task automatic test_zero_hold();
        drive(16'h0000, 1'b0, 1'b1);
        edge_sample();
        n_cmp++;
        if (Y !== 32'h0 || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL zero_se0: got %h/%b want 0/1", Y, out_valid);
        end
        X = 16'h0000; Se = 1'b1; in_valid = 1'b1;
        edge_sample();
        n_cmp++;
        if (Y !== 32'h0 || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL zero_se1: got %h/%b want 0/1", Y, out_valid);
        end
        X = 16'hFFFF; Se = 1'b1; in_valid = 1'b0;
        edge_sample();
        n_cmp++;
        if (Y !== 32'h0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL zero_hold: got %h/%b want 0/0", Y, out_valid);
        end
        // Inputs wiggling between edges with in_valid high mid-cycle only must not capture.
        #2 X = 16'h9999; in_valid = 1'b1;
        #2 in_valid = 1'b0;
        edge_sample();
        n_cmp++;
        if (Y !== 32'h0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL glitch_ignore: got %h/%b want 0/0", Y, out_valid);
        end
    endtask

    task automatic test_async_reset();
        drive(16'h8003, 1'b1, 1'b1);
        edge_sample();
        n_cmp++;
        if (Y !== 32'hFFFF8003) begin n_bad++; $display("FAIL arst_pre: got %h want %h", Y, 32'hFFFF8003); end
        // Pending capture (in_valid still high) plus reset between edges.
        X = 16'h1111; Se = 1'b0; in_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (Y !== 32'h0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL arst_immediate: got %h/%b want 0/0", Y, out_valid);
        end
        edge_sample();
        n_cmp++;
        if (Y !== 32'h0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL arst_held: got %h/%b want 0/0", Y, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1; X = 16'hFFFF; Se = 1'b1; in_valid = 1'b1;
        edge_sample();
        n_cmp++;
        if (Y !== 32'hFFFFFFFF || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL arst_release: got %h/%b want %h/1", Y, out_valid, 32'hFFFFFFFF);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_y;
        logic        exp_v;
        logic [15:0] rx;
        logic        rse, rv;
        int          bad_here;
        exp_y = 32'hFFFFFFFF;
        bad_here = 0;
        for (int i = 0; i < 1000; i++) begin
            rx  = 16'($urandom);
            rse = 1'($urandom);
            rv  = 1'($urandom);
            drive(rx, rse, rv);
            edge_sample();
            exp_v = rv;
            if (rv) exp_y = rse ? {{16{rx[15]}}, rx} : {16'h0, rx};
            n_cmp++;
            if (Y !== exp_y || out_valid !== exp_v) begin
                n_bad++;
                if (bad_here < 10)
                    $display("FAIL random[%0d]: got %h/%b want %h/%b", i, Y, out_valid, exp_y, exp_v);
                bad_here++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_ext();
        test_sign_ext();
        test_back_to_back();
        test_zero_hold();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
